// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: opcodes, datapath mux selects,
// multi-cycle state enumeration and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WR    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Opcode/memory handshake in, datapath controls out. The datapath side is the
// master; the control unit is the slave.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
);
  logic [OPCODE_W-1:0] instr_op;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic [1:0]          pc_source;
  logic                illegal_op;
  logic [STATE_W-1:0]  state;

  modport master (
    output instr_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );

  modport slave (
    input  instr_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, illegal_op, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: one step per clock, stalls on mem_ready.
//
// state     | meaning
// FETCH     | read instr at PC, PC+4; IR/PC load on mem_ready
// DECODE    | latch opcode, precompute branch target
// R_EXEC    | ALU on regA/regB with funct
// R_WB      | write ALUOut to rd
// MEM_ADDR  | compute load/store address
// MEM_RD    | data read, wait for mem_ready
// MEM_WB    | write MDR to rt
// MEM_WR    | data write, wait for mem_ready
// BRANCH    | compare, PC <- ALUOut if zero
// ADDI_EXEC | regA + imm
// ADDI_WB   | write ALUOut to rt
// JUMP      | PC <- jump target
// ILLEGAL   | flag illegal opcode, no side effects
module multicycle_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int STATE_W     = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  multicycle_control_unit_if.slave bus
);

  state_e              r_state;
  state_e              w_next;
  logic [OPCODE_W-1:0] r_op;
  logic                r_illegal;
  ctrl_t               w_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= bus.instr_op;
        if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        w_next = S_ILLEGAL;
        if (bus.instr_op == OPCODE_W'(OP_RTYPE))
          w_next = S_R_EXEC;
        else if (bus.instr_op == OPCODE_W'(OP_LW) || bus.instr_op == OPCODE_W'(OP_SW))
          w_next = S_MEM_ADDR;
        else if (bus.instr_op == OPCODE_W'(OP_BEQ))
          w_next = S_BRANCH;
        else if (ENABLE_ADDI && bus.instr_op == OPCODE_W'(OP_ADDI))
          w_next = S_ADDI_EXEC;
        else if (ENABLE_JUMP && bus.instr_op == OPCODE_W'(OP_J))
          w_next = S_JUMP;
      end
      S_R_EXEC:    w_next = S_R_WB;
      S_MEM_ADDR:  w_next = (r_op == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    w_next = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    w_next = bus.mem_ready ? S_FETCH : S_MEM_WR;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      default:     w_next = S_FETCH;
    endcase
  end

  // Only the FETCH IR/PC loads are qualified by mem_ready, so a stalled fetch
  // leaves PC and IR untouched; all other outputs follow the state alone.
  always_comb begin
    w_ctrl = '0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.alu_src_b = SRCB_FOUR;
          w_ctrl.ir_write  = bus.mem_ready;
          w_ctrl.pc_write  = bus.mem_ready;
        end
        S_DECODE:    w_ctrl.alu_src_b = SRCB_IMM_SH2;
        S_R_EXEC: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          w_ctrl.reg_dst   = 1'b1;
          w_ctrl.reg_write = 1'b1;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          w_ctrl.alu_src_a = 1'b1;
          w_ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          w_ctrl.mem_to_reg = 1'b1;
          w_ctrl.reg_write  = 1'b1;
        end
        S_MEM_WR: begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.i_or_d    = 1'b1;
        end
        S_BRANCH: begin
          w_ctrl.alu_src_a     = 1'b1;
          w_ctrl.alu_op        = ALU_SUB;
          w_ctrl.pc_write_cond = 1'b1;
          w_ctrl.pc_source     = PCSRC_ALUOUT;
        end
        S_ADDI_WB:   w_ctrl.reg_write = 1'b1;
        S_JUMP: begin
          w_ctrl.pc_write  = 1'b1;
          w_ctrl.pc_source = PCSRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign bus.i_or_d        = w_ctrl.i_or_d;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.reg_dst       = w_ctrl.reg_dst;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.alu_op        = w_ctrl.alu_op;
  assign bus.pc_source     = w_ctrl.pc_source;
  assign bus.illegal_op    = r_illegal;
  assign bus.state         = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus queues the expected
// per-cycle state/control word, a negedge monitor pops and compares.
module tb_multicycle_control_unit;
  import mips_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OPCODE_W(6), .STATE_W(4)) bus0 ();
  multicycle_control_unit_if #(.OPCODE_W(6), .STATE_W(4)) bus1 ();

  multicycle_control_unit #(.OPCODE_W(6), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1), .STATE_W(4))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_control_unit #(.OPCODE_W(6), .ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b1), .STATE_W(4))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int          sel;
    logic [3:0]  st;
    logic [16:0] ctl;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_ill [2];

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
  //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op}
  function automatic logic [16:0] act_ctl(int sel);
    if (sel == 0)
      return {bus0.pc_write, bus0.pc_write_cond, bus0.i_or_d, bus0.mem_read, bus0.mem_write,
              bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write, bus0.alu_src_a,
              bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.illegal_op};
    else
      return {bus1.pc_write, bus1.pc_write_cond, bus1.i_or_d, bus1.mem_read, bus1.mem_write,
              bus1.ir_write, bus1.mem_to_reg, bus1.reg_dst, bus1.reg_write, bus1.alu_src_a,
              bus1.alu_src_b, bus1.alu_op, bus1.pc_source, bus1.illegal_op};
  endfunction

  function automatic logic [3:0] act_st(int sel);
    return (sel == 0) ? bus0.state : bus1.state;
  endfunction

  function automatic logic [16:0] exp_ctl(state_e s, logic rdy, logic ill);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ao, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = 10'b0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      S_FETCH:     begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE:    sb = 2'b11;
      S_R_EXEC:    begin sa = 1'b1; ao = 2'b10; end
      S_R_WB:      begin rd = 1'b1; rw = 1'b1; end
      S_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
      S_MEM_RD:    begin mr = 1'b1; iod = 1'b1; end
      S_MEM_WB:    begin m2r = 1'b1; rw = 1'b1; end
      S_MEM_WR:    begin mw = 1'b1; iod = 1'b1; end
      S_BRANCH:    begin sa = 1'b1; ao = 2'b01; pwc = 1'b1; ps = 2'b01; end
      S_ADDI_EXEC: begin sa = 1'b1; sb = 2'b10; end
      S_ADDI_WB:   rw = 1'b1;
      S_JUMP:      begin pw = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
  endfunction

  task automatic step(int sel, logic [5:0] op, logic rdy, state_e st, string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if (sel == 0) begin
      bus0.instr_op = op; bus0.mem_ready = rdy; bus1.mem_ready = 1'b0;
    end else begin
      bus1.instr_op = op; bus1.mem_ready = rdy; bus0.mem_ready = 1'b0;
    end
    if (st == S_ILLEGAL) exp_ill[sel] = 1'b1;
    e.sel = sel; e.st = st; e.ctl = exp_ctl(st, rdy, exp_ill[sel]); e.name = name;
    q.push_back(e);
  endtask

  task automatic reset_step(string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_ill[0] = 1'b0; exp_ill[1] = 1'b0;
    e.sel = 0; e.st = S_FETCH; e.ctl = 17'b0; e.name = name;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (act_st(e.sel) !== e.st || act_ctl(e.sel) !== e.ctl) begin
          n_fail++;
          $display("FAIL %s: dut%0d got state=%0d ctl=%b, expected state=%0d ctl=%b",
                   e.name, e.sel, act_st(e.sel), act_ctl(e.sel), e.st, e.ctl);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus0.instr_op = '0; bus0.mem_ready = 1'b0;
    bus1.instr_op = '0; bus1.mem_ready = 1'b0;
    exp_ill[0] = 1'b0; exp_ill[1] = 1'b0;
    repeat (2) @(posedge clk);
    reset_step("rst_hold");

    // R-type interrupted by reset in R_WB
    step(0, OP_RTYPE, 1'b1, S_FETCH,  "rst_release_fetch");
    step(0, OP_RTYPE, 1'b1, S_DECODE, "rmid_decode");
    step(0, OP_RTYPE, 1'b1, S_R_EXEC, "rmid_exec");
    step(0, OP_RTYPE, 1'b1, S_R_WB,   "rmid_wb");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_ill[0] = 1'b0; exp_ill[1] = 1'b0;
    #1;
    n_tests++;
    if (bus0.reg_write !== 1'b0 || act_ctl(0) !== 17'b0 || bus0.state !== S_FETCH) begin
      n_fail++;
      $display("FAIL rst_mid_rwb: reg_write=%b ctl=%b state=%0d, expected reg_write=0 ctl=0 state=%0d",
               bus0.reg_write, act_ctl(0), bus0.state, S_FETCH);
    end
    reset_step("rst_again");

    // R-type
    step(0, OP_RTYPE, 1'b1, S_FETCH,  "r_fetch");
    step(0, OP_RTYPE, 1'b1, S_DECODE, "r_decode");
    step(0, OP_RTYPE, 1'b1, S_R_EXEC, "r_exec");
    step(0, OP_RTYPE, 1'b1, S_R_WB,   "r_wb");
    // lw with two stalled MEM_RD cycles
    step(0, OP_LW, 1'b1, S_FETCH,    "lw_fetch");
    step(0, OP_LW, 1'b1, S_DECODE,   "lw_decode");
    step(0, OP_LW, 1'b1, S_MEM_ADDR, "lw_addr");
    step(0, OP_LW, 1'b0, S_MEM_RD,   "lw_rd_stall1");
    step(0, OP_LW, 1'b0, S_MEM_RD,   "lw_rd_stall2");
    step(0, OP_LW, 1'b1, S_MEM_RD,   "lw_rd_done");
    step(0, OP_LW, 1'b1, S_MEM_WB,   "lw_wb");
    // stalled fetch, then sw
    step(0, OP_SW, 1'b0, S_FETCH,    "fetch_stall");
    step(0, OP_SW, 1'b1, S_FETCH,    "sw_fetch");
    step(0, OP_SW, 1'b1, S_DECODE,   "sw_decode");
    step(0, OP_SW, 1'b1, S_MEM_ADDR, "sw_addr");
    step(0, OP_SW, 1'b1, S_MEM_WR,   "sw_wr");
    // sw with one stalled write cycle
    step(0, OP_SW, 1'b1, S_FETCH,    "sw2_fetch");
    step(0, OP_SW, 1'b1, S_DECODE,   "sw2_decode");
    step(0, OP_SW, 1'b1, S_MEM_ADDR, "sw2_addr");
    step(0, OP_SW, 1'b0, S_MEM_WR,   "sw2_wr_stall");
    step(0, OP_SW, 1'b1, S_MEM_WR,   "sw2_wr_done");
    // beq, j, addi
    step(0, OP_BEQ, 1'b1, S_FETCH,  "beq_fetch");
    step(0, OP_BEQ, 1'b1, S_DECODE, "beq_decode");
    step(0, OP_BEQ, 1'b1, S_BRANCH, "beq_branch");
    step(0, OP_J,   1'b1, S_FETCH,  "j_fetch");
    step(0, OP_J,   1'b1, S_DECODE, "j_decode");
    step(0, OP_J,   1'b1, S_JUMP,   "j_jump");
    step(0, OP_ADDI, 1'b1, S_FETCH,     "addi_fetch");
    step(0, OP_ADDI, 1'b1, S_DECODE,    "addi_decode");
    step(0, OP_ADDI, 1'b1, S_ADDI_EXEC, "addi_exec");
    step(0, OP_ADDI, 1'b1, S_ADDI_WB,   "addi_wb");
    // illegal opcode, then a jump to confirm the flag is sticky
    step(0, 6'b111111, 1'b1, S_FETCH,   "ill_fetch");
    step(0, 6'b111111, 1'b1, S_DECODE,  "ill_decode");
    step(0, 6'b111111, 1'b1, S_ILLEGAL, "ill_state");
    step(0, OP_J, 1'b1, S_FETCH,  "ill_j_fetch");
    step(0, OP_J, 1'b1, S_DECODE, "ill_j_decode");
    step(0, OP_J, 1'b1, S_JUMP,   "ill_j_jump");
    step(0, OP_J, 1'b0, S_FETCH,  "ill_park");
    // addi disabled: treated as illegal
    step(1, OP_ADDI, 1'b1, S_FETCH,   "noaddi_fetch");
    step(1, OP_ADDI, 1'b1, S_DECODE,  "noaddi_decode");
    step(1, OP_ADDI, 1'b1, S_ILLEGAL, "noaddi_illegal");
    step(1, OP_ADDI, 1'b0, S_FETCH,   "noaddi_back_fetch");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
